alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/writeback controller that drives the datapath ALU from the register-file side. It accepts one instruction (opcode plus register addresses) and reads both source operands from the register file. It then presents dat1/dat2/op to the ALU, captures up/low/ze, and writes the results back. It is the producer of ALU operands and the consumer of ALU results, sitting between instruction decode and the ALU/register file.

Parameters:
UPPER_REG, 15, register-file address that receives the upper 16 bits of a wide (op[3]=1) result
DW, 16, datapath width (ALU operand/result width)
AW, 4, register-file address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  instruction valid; sampled only in IDLE
ins_op  input  4  ALU opcode
ins_a  input  AW  source register for dat1
ins_b  input  AW  source register for dat2
ins_d  input  AW  destination register for lower result
busy  output  1  high from the cycle after start is accepted through the final writeback cycle
done  output  1  one-cycle pulse coincident with the final writeback write
rf_ra  output  AW  register-file read address A (combinational read)
rf_rb  output  AW  register-file read address B
rf_rdata_a  input  DW  read data A
rf_rdata_b  input  DW  read data B
dat1  output  DW  ALU operand 1 (registered)
dat2  output  DW  ALU operand 2 (registered)
op  output  4  ALU opcode (registered)
up  input  DW  ALU upper result
low  input  DW  ALU lower result
ze  input  1  ALU zero flag
rf_we  output  1  register-file write enable
rf_wa  output  AW  write address
rf_wd  output  DW  write data
zero_flag  output  1  ze captured from the most recent executed instruction

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, rf_we, zero_flag=0. dat1, dat2, rf_wd=0. op, rf_ra, rf_rb, rf_wa=0. Latched instruction cleared. Any in-flight instruction is abandoned with no write.
- FSM states: IDLE, READ, EXEC, WB_LO, WB_HI.
- IDLE:
  - start=1 latches ins_op/a/b/d.
  - Next state READ; busy=1 from the next cycle.
  - start=0 holds IDLE.
- READ:
  - rf_ra=latched a, rf_rb=latched b.
  - At the clock edge, dat1<=rf_rdata_a, dat2<=rf_rdata_b, op<=latched op.
  - Next state EXEC.
- EXEC:
  - dat1/dat2/op held stable for one full cycle so the combinational ALU settles.
  - At the edge, capture up/low into result registers and ze into zero_flag.
  - Next state WB_LO.
- WB_LO:
  - rf_we=1, rf_wa=latched d, rf_wd=captured low.
  - If op[3]=1, next state WB_HI.
  - Otherwise done=1 this cycle and next state IDLE.
- WB_HI:
  - rf_we=1, rf_wa=UPPER_REG, rf_wd=captured up.
  - done=1; next state IDLE.
- Latency from start-accept edge at cycle N:
  - Narrow ops: write and done in cycle N+3.
  - Wide ops: lower write in N+3; upper write and done in N+4.
- Throughput: a new start is accepted at the earliest in the cycle after done (IDLE). start while busy, including the done cycle, is ignored and not queued.
- Operands after start: dat1/dat2/op keep their last values until the next READ edge; the ALU inputs never go X after reset.
- Hazards:
  - Wide op with d==UPPER_REG: both writes occur, and the upper write (later) is the final register value.
  - Source == destination reads the pre-write value.
- Opcodes are forwarded untouched; this block does not interpret arithmetic beyond op[3].
- rf_we is 0 in IDLE/READ/EXEC. rf_wa/rf_wd hold their last values when rf_we=0.

Test Plan:
- Reset then idle, no start for 10 cycles -> busy, done, rf_we, dat1, dat2, op all 0; no writes.
- R1=000F, R2=0001; start op=0 a=1 b=2 d=3 -> dat1=000F, dat2=0001, op=0 in EXEC; rf_we with wa=3, wd=ALU low (0010 from add model) and done at N+3; zero_flag=0.
- R1=0A00, R2=00F0, op=1, d=4 -> single write of 0910 to R4 at N+3; done at N+3; busy low at N+4.
- R5=00FF, R6=F0F0, op=1001b, d=7, bench ALU returns up=00EF, low=FF10 -> write R7=FF10 at N+3, R15=00EF at N+4, done only at N+4. Repeat with d=15 -> R15 ends 00EF.
- Sub with R8=1234, R8 (a=b=8), ALU ze=1 -> zero_flag=1 after EXEC; extra start pulses during busy and on the done cycle -> ignored, exactly one write.
- Assert rst=0 mid-WB_LO -> rf_we, done, busy drop immediately (asynchronous); no WB_HI; after release, state is IDLE and the next start executes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Multi-cycle issue/writeback controller between instruction
//            decode, the register file and a combinational ALU. It accepts one
//            instruction, reads both source operands and presents registered
//            operands/opcode to the ALU. It then captures up/low/ze and writes
//            the low result to the destination register. Wide ops (op[3]=1)
//            also write the upper result to UPPER_REG.
// Ports    : clk_i/rst_ni          clock, asynchronous active-low reset
//            start_i, ins_*_i      instruction handshake (sampled in IDLE)
//            busy_o, done_o        status
//            rf_ra_o/rf_rb_o       register-file read addresses
//            rf_rdata_a/b_i        register-file read data (combinational)
//            dat1_o/dat2_o/op_o    registered ALU operands and opcode
//            up_i/low_i/ze_i       ALU results
//            rf_we_o/wa_o/wd_o     register-file write port
//            zero_flag_o           ze of the most recently executed instruction
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int UPPER_REG = 15,
  parameter int DW        = 16,
  parameter int AW        = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [3:0]    ins_op_i,
  input  logic [AW-1:0] ins_a_i,
  input  logic [AW-1:0] ins_b_i,
  input  logic [AW-1:0] ins_d_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] rf_ra_o,
  output logic [AW-1:0] rf_rb_o,
  input  logic [DW-1:0] rf_rdata_a_i,
  input  logic [DW-1:0] rf_rdata_b_i,
  output logic [DW-1:0] dat1_o,
  output logic [DW-1:0] dat2_o,
  output logic [3:0]    op_o,
  input  logic [DW-1:0] up_i,
  input  logic [DW-1:0] low_i,
  input  logic          ze_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_wa_o,
  output logic [DW-1:0] rf_wd_o,
  output logic          zero_flag_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB_LO = 3'd3;
  localparam logic [2:0] S_WB_HI = 3'd4;

  localparam logic [AW-1:0] C_UPPER_ADDR = AW'(UPPER_REG);

  logic [2:0]    state_q, state_d;

  // Latched instruction fields
  logic [3:0]    ins_op_q;
  logic [AW-1:0] ins_a_q;
  logic [AW-1:0] ins_b_q;
  logic [AW-1:0] ins_d_q;

  // Operand / result registers
  logic [DW-1:0] dat1_q, dat2_q;
  logic [3:0]    op_q;
  logic [DW-1:0] res_up_q, res_lo_q;
  logic          zero_q;

  // Last written address/data, so the write port holds its value while idle
  logic [AW-1:0] last_wa_q;
  logic [DW-1:0] last_wd_q;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB_LO;
      S_WB_LO: state_d = op_q[3] ? S_WB_HI : S_IDLE;
      S_WB_HI: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    busy_o  = 1'b0;
    done_o  = 1'b0;
    rf_we_o = 1'b0;
    rf_wa_o = last_wa_q;
    rf_wd_o = last_wd_q;
    case (state_q)
      S_READ, S_EXEC: begin
        busy_o = 1'b1;
      end
      S_WB_LO: begin
        busy_o  = 1'b1;
        rf_we_o = 1'b1;
        rf_wa_o = ins_d_q;
        rf_wd_o = res_lo_q;
        done_o  = ~op_q[3];
      end
      S_WB_HI: begin
        busy_o  = 1'b1;
        rf_we_o = 1'b1;
        rf_wa_o = C_UPPER_ADDR;
        rf_wd_o = res_up_q;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ins_op_q  <= '0;
      ins_a_q   <= '0;
      ins_b_q   <= '0;
      ins_d_q   <= '0;
      dat1_q    <= '0;
      dat2_q    <= '0;
      op_q      <= '0;
      res_up_q  <= '0;
      res_lo_q  <= '0;
      zero_q    <= 1'b0;
      last_wa_q <= '0;
      last_wd_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        ins_op_q <= ins_op_i;
        ins_a_q  <= ins_a_i;
        ins_b_q  <= ins_b_i;
        ins_d_q  <= ins_d_i;
      end
      if (state_q == S_READ) begin
        dat1_q <= rf_rdata_a_i;
        dat2_q <= rf_rdata_b_i;
        op_q   <= ins_op_q;
      end
      if (state_q == S_EXEC) begin
        res_up_q <= up_i;
        res_lo_q <= low_i;
        zero_q   <= ze_i;
      end
      if (rf_we_o) begin
        last_wa_q <= rf_wa_o;
        last_wd_q <= rf_wd_o;
      end
    end
  end

  // Read addresses follow the latched sources; they only matter in READ.
  assign rf_ra_o     = ins_a_q;
  assign rf_rb_o     = ins_b_q;
  assign dat1_o      = dat1_q;
  assign dat2_o      = dat2_q;
  assign op_o        = op_q;
  assign zero_flag_o = zero_q;

endmodule
`default_nettype wire
